rf_wb_arbiter: RTL
==================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, register address width.
REQ-002 SHALL have parameter DATA_W, default 32, register data width.
REQ-003 SHALL have parameter CNT_W, default 16, conflict-counter width.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-006 SHALL have port hold  input  1  pipeline stall; while 1 no request is granted.
REQ-007 SHALL have ports req0_valid/req1_valid  input  1  requester N has a write pending.
REQ-008 SHALL have ports req0_addr/req1_addr  input  ADDR_W  destination register of requester N.
REQ-009 SHALL have ports req0_data/req1_data  input  DATA_W  write data of requester N.
REQ-010 SHALL have ports req0_ready/req1_ready  output  1  requester N transfer accepted this cycle.
REQ-011 SHALL have port rf_we  output  1  write enable to the register file.
REQ-012 SHALL have port rf_wa  output  ADDR_W  write address to the register file.
REQ-013 SHALL have port rf_wd  output  DATA_W  write data to the register file.
REQ-014 SHALL have port conflict_cnt  output  CNT_W  cycles in which both requesters were valid and one was refused.

Function
REQ-015 SHALL define a transfer as reqN_valid & reqN_ready at a rising clk edge.
REQ-016 SHALL drive reqN_ready combinationally: 1 only for the granted requester, and only when hold=0; never both 1.
REQ-017 SHALL grant a lone valid requester regardless of priority pointer.
REQ-018 SHALL, with both valid, grant the requester not recorded in last_grant (round-robin); after reset last_grant=1, so req0 wins the first tie.
REQ-019 SHALL update last_grant only on a transfer; hold or no-valid cycles leave it unchanged.
REQ-020 SHALL register outputs: a transfer at edge k yields rf_we=1, rf_wa/rf_wd = accepted addr/data for the cycle after edge k (latency 1 cycle).
REQ-021 SHALL drive rf_we=0 in any cycle not following a transfer; rf_wa/rf_wd hold their last values.
REQ-022 SHALL accept transfers to address 0 (ready asserted, handshake completes) but keep rf_we=0 for them (register 0 is hardwired zero).
REQ-023 SHALL sustain one transfer per cycle; back-to-back transfers from alternating requesters produce rf_we=1 on consecutive cycles.
REQ-024 SHALL treat same-address requests from both requesters as an ordinary tie: winner written first, loser written on a later cycle (loser's value is final).
REQ-025 SHALL increment conflict_cnt on each edge where both valid, hold=0 and one is refused; saturate at all ones, never wrap.
REQ-026 SHALL not count hold cycles as conflicts.
REQ-027 SHALL require requesters to keep valid, addr, data stable until their transfer; arbiter behaviour under payload change before transfer is undefined.

Reset
REQ-028 SHALL, while reset=0, force rf_we=0, rf_wa=0, rf_wd=0, conflict_cnt=0, last_grant=1, reqN_ready=0, asynchronously.
REQ-029 SHALL discard any transfer coinciding with reset assertion; no rf_we pulse after reset release without a new transfer.
REQ-030 SHALL resume arbitration on the first rising edge after reset returns to 1.

Structure
REQ-031 SHALL place ADDR_W, DATA_W, CNT_W defaults and the requester-id type (REQ0, REQ1) in shared package rf_pkg, also used by the register file.
REQ-032 SHALL implement the grant logic and last_grant pointer in one sub-module rr_arb2 (two-way round-robin arbiter); output register and counter in top level.

Verification
REQ-033 SHALL test reset: reset=0 mid-transfer with req0 valid (addr 19, data 121) -> rf_we=0, conflict_cnt=0 immediately; no write after release until new handshake.
REQ-034 SHALL test single requester: req1 valid addr 13 data 45, hold=0 -> req1_ready=1 same cycle; next cycle rf_we=1, rf_wa=13, rf_wd=45.
REQ-035 SHALL test tie/round-robin: both valid continuously (req0 addr 19/121, req1 addr 13/45, reloaded each transfer) for 4 cycles -> grant order 0,1,0,1; conflict_cnt=4.
REQ-036 SHALL test hold: both valid, hold=1 for 3 cycles -> no ready, rf_we=0, conflict_cnt unchanged, last_grant unchanged; first grant after hold goes to pointer-preferred requester.
REQ-037 SHALL test register 0: req0 valid addr 0 data 99 -> req0_ready=1, next cycle rf_we=0.
REQ-038 SHALL test saturation with CNT_W=2: 5 conflict cycles -> conflict_cnt stays 3.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared register-file definitions: default widths and requester identifiers,
// used by the write-back arbiter and the register file itself.
package rf_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam int RF_CNT_W  = 16;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grants plus the last_grant pointer,
// which only moves when a grant actually completes a transfer.
module rr_arb2
  import rf_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic hold,
  input  logic valid0,
  input  logic valid1,
  output logic grant0,
  output logic grant1,
  output logic conflict
);

  req_id_t last_grant;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= REQ1;
    end else if (grant0) begin
      last_grant <= REQ0;
    end else if (grant1) begin
      last_grant <= REQ1;
    end
  end

  // Grants are gated by reset so no ready is ever shown while in reset.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (reset && !hold) begin
      if (valid0 && valid1) begin
        if (last_grant == REQ1) begin
          grant0 = 1'b1;
        end else begin
          grant1 = 1'b1;
        end
      end else begin
        grant0 = valid0;
        grant1 = valid1;
      end
    end
  end

  assign conflict = valid0 & valid1 & ~hold;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter: two requesters share one write port; the
// accepted write is registered one cycle later and refused ties are counted.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W,
  parameter int CNT_W  = RF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req0_ready,
  output logic              req1_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic [CNT_W-1:0]  conflict_cnt
);

  logic              grant0;
  logic              grant1;
  logic              conflict;
  logic              xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  rr_arb2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .hold     (hold),
    .valid0   (req0_valid),
    .valid1   (req1_valid),
    .grant0   (grant0),
    .grant1   (grant1),
    .conflict (conflict)
  );

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign xfer       = grant0 | grant1;
  assign sel_addr   = grant1 ? req1_addr : req0_addr;
  assign sel_data   = grant1 ? req1_data : req0_data;

  // Register 0 is hardwired zero: its transfers complete but never write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
    end else begin
      rf_we <= xfer && (sel_addr != '0);
      if (xfer && (sel_addr != '0)) begin
        rf_wa <= sel_addr;
        rf_wd <= sel_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflict_cnt <= '0;
    end else if (conflict && (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule
